// File: rtl/soc_system_ogpu_quad_load_cmd.sv
// HPS-written Avalon-MM slave that stages 64-bit quad load words and queues them to the GPU.
// Optional irq output and STATUS enable bit are built when OGPU_QUAD_LOAD_IRQ_EN is defined.
`timescale 1ns/1ps
module soc_system_ogpu_quad_load_cmd #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
`ifdef OGPU_QUAD_LOAD_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Valid/ready: a word transfers on any rising edge where out_valid and out_ready
    // are both high; out_valid never depends on out_ready.

    logic [31:0]   datal;
    logic [31:0]   datah;
    logic [63:0]   storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic          wr_en;
    logic          push_req;
    logic          pop;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          flush;
    logic          ovf_clr;
    logic          ovf_set;
    logic [7:0]    count8;
    logic [31:0]   status;
    logic [31:0]   rd_mux;

`ifdef OGPU_QUAD_LOAD_IRQ_EN
    logic          ien;
`endif

    always_comb begin
        wr_en    = chipselect & ~write_n;
        push_req = wr_en & (address == 2'd2);
        empty    = (count == '0);
        full     = (count == DEPTH_C);
        pop      = out_valid & out_ready;
        push_ok  = push_req & (~full | pop);
        flush    = wr_en & (address == 2'd3) & writedata[1];
        ovf_clr  = wr_en & (address == 2'd3) & writedata[0];
        ovf_set  = push_req & full & ~pop;
        count8   = 8'(count);
`ifdef OGPU_QUAD_LOAD_IRQ_EN
        status   = {16'b0, count8, 4'b0, ien, ovf, full, empty};
`else
        status   = {16'b0, count8, 5'b0, ovf, full, empty};
`endif
    end

    assign out_valid = ~empty;
    assign out_data  = storage[rd_ptr];

    always_comb begin
        rd_mux = '0;
        unique case (address)
            2'd0: rd_mux = datal;
            2'd1: rd_mux = datah;
            2'd2: rd_mux = '0;
            2'd3: rd_mux = status;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            datal    <= '0;
            datah    <= '0;
            ovf      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            if (wr_en && address == 2'd0) datal <= writedata;
            if (wr_en && address == 2'd1) datah <= writedata;
            // A new overflow in the same cycle as a clear keeps the flag set.
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (push_ok) begin
            storage[wr_ptr] <= {datah, datal};
        end
    end

`ifdef OGPU_QUAD_LOAD_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ien <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_en && address == 2'd3) ien <= writedata[2];
            irq <= ien & (empty | ovf);
        end
    end
`endif

endmodule
